// File: rtl/mc_boot_pkg.sv
// Shared constants for the boot loader: FSM state encoding and frame field sizes.
package mc_boot_pkg;

  localparam logic [2:0] S_ADDR  = 3'd0;
  localparam logic [2:0] S_CNT   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam int ADDR_BYTES = 4;
  localparam int CNT_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  function automatic logic is_rx_state(input logic [2:0] s);
    return (s == S_ADDR) || (s == S_CNT) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/mc_byte_packer.sv
// MSB-first byte accumulator; 'full' flags the byte that completes a field of 'len' bytes.
module mc_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic        take,
  input  logic [2:0]  len,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        full
);

  logic [31:0] word;
  logic [2:0]  cnt;

  // Consumers latch word_next on the completing byte, so the field costs no extra cycle.
  assign word_next = {word[23:0], byte_in};
  assign full      = shift_en && (cnt == len - 3'd1);

  // NOTE: non-blocking assignments in clocked blocks make every flop update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (take) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      word <= word_next;
      cnt  <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/mc_boot_loader.sv
// Byte-stream program loader: writes the image, then sequences CPU reset release.
// Optional trailing XOR checksum byte is enabled by defining BOOT_CHECKSUM_EN.
module mc_boot_loader
  import mc_boot_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32,
  parameter int RST_HOLD  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_done,
  output logic              o_err
);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [15:0]       n_words, k, hold_cnt;
  logic              accept, pk_shift, pk_full;
  logic [2:0]        pk_len;
  logic [31:0]       pk_word_next;
  logic [ADDR_W:0]   wr_addr, wr_last;
  logic              out_of_range;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept   = o_rx_ready && i_rx_valid;
  assign pk_shift = accept && ((state == S_ADDR) || (state == S_CNT) || (state == S_DATA));
  assign pk_len   = (state == S_CNT)  ? 3'(CNT_BYTES)  :
                    (state == S_ADDR) ? 3'(ADDR_BYTES) : 3'(WORD_BYTES);

  // One extra bit so an address that wraps past 2^ADDR_W still reads as out of range.
  assign wr_addr      = (ADDR_W+1)'(base) + ((ADDR_W+1)'(k) << 2);
  assign wr_last      = wr_addr + (ADDR_W+1)'(3);
  assign out_of_range = wr_last >= (ADDR_W+1)'(MEM_BYTES);

  mc_byte_packer u_packer (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .shift_en  (pk_shift),
    .take      (pk_full),
    .len       (pk_len),
    .byte_in   (i_rx_data),
    .word_next (pk_word_next),
    .full      (pk_full)
  );

  // NOTE: defaulting state_nxt before the case keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ADDR:  if (pk_full) state_nxt = S_CNT;
      S_CNT:   if (pk_full) begin
                 if (base[1:0] != 2'b00)          state_nxt = S_ERR;
                 else if (pk_word_next[15:0] == 0) state_nxt = S_HOLD;
                 else                              state_nxt = S_DATA;
               end
      S_DATA:  if (pk_full) state_nxt = out_of_range ? S_ERR : S_WRITE;
      S_WRITE: begin
                 if (k != n_words - 16'd1) state_nxt = S_DATA;
`ifdef BOOT_CHECKSUM_EN
                 else                      state_nxt = S_CSUM;
`else
                 else                      state_nxt = S_HOLD;
`endif
               end
`ifdef BOOT_CHECKSUM_EN
      S_CSUM:  if (accept) state_nxt = (i_rx_data == csum) ? S_HOLD : S_ERR;
`endif
      S_HOLD:  if (hold_cnt == 16'(RST_HOLD - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Outputs are registered from state_nxt so they are glitch-free and all zero in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_ADDR;
      base        <= '0;
      n_words     <= '0;
      k           <= '0;
      hold_cnt    <= '0;
      o_rx_ready  <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_cpu_rst_n <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_rx_ready  <= is_rx_state(state_nxt);
      o_mem_we    <= (state_nxt == S_WRITE);
      o_cpu_rst_n <= (state_nxt == S_DONE);
      o_done      <= (state_nxt == S_DONE);
      o_err       <= (state_nxt == S_ERR);
      if (state == S_ADDR && pk_full) base    <= ADDR_W'(pk_word_next);
      if (state == S_CNT  && pk_full) n_words <= pk_word_next[15:0];
      if (state == S_DATA && state_nxt == S_WRITE) begin
        o_mem_addr  <= wr_addr[ADDR_W-1:0];
        o_mem_wdata <= pk_word_next;
      end
      if (state == S_WRITE) k        <= k + 16'd1;
      if (state == S_HOLD)  hold_cnt <= hold_cnt + 16'd1;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      csum <= '0;
    else if (pk_shift) csum <= csum ^ i_rx_data;
  end
`endif

endmodule

// File: doc/mc_boot_loader.md
Name: mc_boot_loader

Overview:
- Loads a program image into the multi-cycle CPU's byte-addressed unified memory from a byte stream, then releases the CPU from reset.
- Sits between a host byte source (UART RX or bench driver) and the memory write port; owns CPU reset sequencing.
- Write-side counterpart of the end-of-run memory/register dump: image in at boot, dump out at halt.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; writes must stay below this.
- ADDR_W, 32, memory address width.
- RST_HOLD, 4, cycles o_cpu_rst_n stays low after load completes, before release.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_data  in  8  stream byte
- i_rx_valid  in  1  byte present
- o_rx_ready  out  1  loader accepts byte; transfer when valid&&ready
- o_mem_we  out  1  one-cycle word write strobe
- o_mem_addr  out  ADDR_W  byte address of word MSB
- o_mem_wdata  out  32  word; [31:24] goes to mem[addr], [7:0] to mem[addr+3]
- o_cpu_rst_n  out  1  CPU reset, active low
- o_done  out  1  load finished, CPU released
- o_err  out  1  sticky load error

Behaviour:
- One clock; reset asynchronous, active-low (i_rst_n). Reset values: all outputs 0, o_mem_addr=0, o_mem_wdata=0; state=S_ADDR; counters 0.
- Frame, all fields big-endian: 4-byte base address, 2-byte word count N, then N data words of 4 bytes each, [checksum byte if enabled].
- States: S_ADDR (collect 4 bytes) -> S_CNT (2 bytes) -> S_DATA (4 bytes) -> S_WRITE (1 cycle) -> S_DATA or S_CSUM/S_HOLD -> S_DONE; S_ERR terminal.
- o_rx_ready=1 only in S_ADDR, S_CNT, S_DATA, S_CSUM. Bytes are consumed only on valid&&ready; a valid with ready low is neither lost nor consumed.
- S_CNT exit: if base[1:0]!=0, go to S_ERR. If N==0, go to S_HOLD (no writes).
- S_WRITE: o_mem_we=1 for exactly one cycle. o_mem_addr = base + 4*k (k = word index 0..N-1), o_mem_wdata = assembled word. Latency from the 4th byte accepted to the we pulse is 1 cycle. Then k++; after k==N-1, go to S_CSUM (macro) or S_HOLD.
- Bounds: if base+4*k+3 >= MEM_BYTES at S_WRITE entry, suppress the write and go to S_ERR. Address arithmetic is done in ADDR_W+1 bits so wrap is detected as an overflow.
- S_HOLD: counts RST_HOLD cycles with o_cpu_rst_n=0, then S_DONE. S_DONE: o_cpu_rst_n=1, o_done=1, o_rx_ready=0; further bytes are ignored.
- S_ERR: o_err=1, o_cpu_rst_n=0, o_rx_ready=0 until i_rst_n.
- Reset mid-frame aborts immediately. Partial writes already issued remain in memory. The CPU is held in reset again.
- Bytes arriving back-to-back every cycle: the loader stalls one cycle per word (S_WRITE) via ready=0.

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined: a trailing byte follows the data. It must equal the XOR of all bytes of address, count and data. On match, go to S_HOLD; on mismatch, go to S_ERR. Memory writes already made are kept.
- Undefined: no S_CSUM state; the frame ends after the last data word.

Decomposition:
- Package mc_boot_pkg: state encoding localparams (S_ADDR..S_ERR, 3 bits), field byte-counts (ADDR_BYTES=4, CNT_BYTES=2, WORD_BYTES=4).
- One sub-module is natural: mc_byte_packer. It shifts in bytes MSB-first up to 4, reports full, and clears on take. It is reused for the address, count and data fields.

Test Plan:
- Frame 00000100 0002 DEADBEEF 01234567 -> we pulses at addr 0x100 data 0xDEADBEEF and at 0x104 data 0x01234567; o_cpu_rst_n rises 4 cycles after the 2nd pulse; o_done=1.
- Base 0x102 -> no we, o_err=1, o_cpu_rst_n stays 0.
- Base 0x3FC, N=2 -> one write at 0x3FC, second suppressed, o_err=1.
- N=0 -> no we; o_done after RST_HOLD cycles.
- i_rx_valid held high continuously -> ready drops exactly 1 cycle per word; every byte lands in order (check bytes BE mem[0x100..0x103]=DE AD BE EF).
- i_rst_n pulsed low after 3 data bytes -> outputs return to reset values immediately; a full new frame then loads correctly. With BOOT_CHECKSUM_EN: a correct XOR byte gives o_done; a corrupted XOR byte gives o_err.
